// File: rtl/md5_candidate_gen.sv
// md5_candidate_gen: brute-force plaintext enumerator feeding md5core.
// Walks an odometer over CHARSET_SIZE consecutive characters starting at
// BASE_CHAR, shortest length first, up to MAX_LEN characters.
// Optional build macro MD5_CANDIDATE_COUNT_EN: when defined, cand_count is
// a live 64-bit candidate index; otherwise it is tied to zero.
//
// Handshake: while valid=1 the candidate on message/length is stable until
// the cycle in which advance=1 is sampled; the next candidate appears one
// cycle later. start (any state) overrides advance and restarts the walk.
module md5_candidate_gen #(
   parameter int         MAX_LEN      = 8,
   parameter logic [7:0] BASE_CHAR    = 8'h61,
   parameter int         CHARSET_SIZE = 26
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [5:0]   start_len,
   input  logic         advance,
   output logic [447:0] message,
   output logic [63:0]  length,
   output logic         valid,
   output logic         done,
   output logic [63:0]  cand_count
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [5:0] MAX_LEN_W  = 6'(MAX_LEN);
   localparam logic [7:0] LAST_DIGIT = 8'(CHARSET_SIZE - 1);

   state_t       state, state_nxt;
   logic [7:0]   digits     [MAX_LEN];
   logic [7:0]   digits_nxt [MAX_LEN];
   logic [5:0]   cur_len, len_nxt;
   logic         load;
   logic         carry;
   logic [447:0] msg_nxt;

   // Next-state: restart on start, otherwise ripple the odometer on advance.
   always_comb begin
      state_nxt  = state;
      len_nxt    = cur_len;
      digits_nxt = digits;
      load       = 1'b0;
      carry      = 1'b0;
      if (start) begin
         state_nxt = RUN;
         load      = 1'b1;
         if (start_len == 6'd0)
            len_nxt = 6'd1;
         else if (start_len > MAX_LEN_W)
            len_nxt = MAX_LEN_W;
         else
            len_nxt = start_len;
         for (int i = 0; i < MAX_LEN; i++)
            digits_nxt[i] = 8'd0;
      end else if (state == RUN && advance) begin
         carry = 1'b1;
         // Carry only ripples through the positions of the current length.
         for (int i = 0; i < MAX_LEN; i++) begin
            if (carry && (6'(i) < cur_len)) begin
               if (digits[i] == LAST_DIGIT) begin
                  digits_nxt[i] = 8'd0;
               end else begin
                  digits_nxt[i] = digits[i] + 8'd1;
                  carry         = 1'b0;
               end
            end
         end
         if (!carry) begin
            load = 1'b1;
         end else if (cur_len < MAX_LEN_W) begin
            // Every active digit wrapped to 0, so the longer string starts all-BASE.
            len_nxt = cur_len + 6'd1;
            load    = 1'b1;
         end else begin
            // Keyspace exhausted: keep showing the last candidate.
            state_nxt = DONE;
         end
      end
   end

   // Pack the next candidate right-justified, digit 0 in the lowest byte.
   always_comb begin
      msg_nxt = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         if (6'(i) < len_nxt)
            msg_nxt[8*i +: 8] = BASE_CHAR + digits_nxt[i];
      end
   end

   // State, odometer and registered md5core-facing outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cur_len <= 6'd1;
         message <= '0;
         length  <= '0;
         for (int i = 0; i < MAX_LEN; i++)
            digits[i] <= 8'd0;
      end else begin
         state   <= state_nxt;
         cur_len <= len_nxt;
         digits  <= digits_nxt;
         if (load) begin
            message <= msg_nxt;
            length  <= {55'd0, len_nxt, 3'b000};
         end
      end
   end

   assign valid = (state == RUN);
   assign done  = (state == DONE);

`ifdef MD5_CANDIDATE_COUNT_EN
   logic [63:0] count_q;

   // Index of the shown candidate; the exhausting advance does not count.
   always_ff @(posedge clk) begin
      if (rst)
         count_q <= 64'd0;
      else if (start)
         count_q <= 64'd0;
      else if (state == RUN && advance && state_nxt == RUN)
         count_q <= count_q + 64'd1;
   end

   assign cand_count = count_q;
`else
   assign cand_count = 64'd0;
`endif

endmodule
